clkdiv_multi: RTL and testbench

Multi-channel, runtime-programmable clock divider. This is the parametrised successor to the single fixed-ratio divider. Each of `CH` channels produces a divided clock-level output and a one-cycle clock-enable pulse from the system clock. Divide ratios are reloaded glitch-free at period boundaries, and a common `sync_i` strobe phase-aligns all channels. The block feeds the peripheral timing logic: UART baud ticks, SPI SCLK and sampling strobes.

---
 rtl/clkdiv_multi.sv | 57 +++++
 tb/tb_clkdiv_multi.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/clkdiv_multi.sv
// clkdiv_multi: per-channel programmable clock divider with shadowed ratio reload and common sync.
// Every channel outputs a registered divided clock, a one-cycle enable pulse and a reload-pending flag.
module clkdiv_multi #(
  parameter int CH      = 4,
  parameter int W       = 8,
  parameter int DEF_DIV = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [CH*W-1:0] div_i,
  input  logic [CH-1:0]   div_load_i,
  input  logic            sync_i,
  output logic [CH-1:0]   clk_o,
  output logic [CH-1:0]   ce_o,
  output logic [CH-1:0]   pend_o
);
  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic [W-1:0] act_q, act_d, shd_q, shd_d, cnt_q, cnt_d, nxt;
    logic [W:0]   half;
    logic         pend_q, pend_d, clk_q, clk_d, ce_q, ce_d, en, wrap, apply, load;
    assign load = div_load_i[g];
    assign nxt  = div_i[g*W +: W];
    // A disabled channel has no boundary to wait for, so a load takes effect immediately.
    always_comb begin
      en     = act_q != '0;
      wrap   = en && cnt_q == act_q - 1'b1;
      apply  = sync_i | wrap | (!en & load);
      shd_d  = load ? nxt : shd_q;
      pend_d = (load | pend_q) & !apply;
      act_d  = (apply && (load | pend_q)) ? shd_d : act_q;
      cnt_d  = (apply || !en) ? '0 : cnt_q + 1'b1;
      half   = ({1'b0, act_d} + 1'b1) >> 1;
      ce_d   = cnt_d == '0 && act_d != '0;
      clk_d  = {1'b0, cnt_d} < half && act_d != '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        act_q  <= W'(DEF_DIV);
        shd_q  <= W'(DEF_DIV);
        cnt_q  <= W'(DEF_DIV - 1);
        pend_q <= 1'b0;
        clk_q  <= 1'b0;
        ce_q   <= 1'b0;
      end else begin
        act_q  <= act_d;
        shd_q  <= shd_d;
        cnt_q  <= cnt_d;
        pend_q <= pend_d;
        clk_q  <= clk_d;
        ce_q   <= ce_d;
      end
    end
    assign clk_o[g]  = clk_q;
    assign ce_o[g]   = ce_q;
    assign pend_o[g] = pend_q;
  end
endmodule

// File: tb/tb_clkdiv_multi.sv
// tb_clkdiv_multi: scoreboard bench for clkdiv_multi; expected waveforms are derived from
// channel phase and ratio, queued with the stimulus and popped when the outputs are sampled.
module tb_clkdiv_multi;
  localparam int CH = 4;
  localparam int W  = 8;
  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [CH*W-1:0] div_i = '0;
  logic [CH-1:0]   div_load_i = '0;
  logic            sync_i = 1'b0;
  logic [CH-1:0]   clk_o, ce_o, pend_o;
  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [CH-1:0] ce, clk, pend, msk;
    string         tag;
  } exp_t;
  exp_t q[$];
  exp_t e;

  clkdiv_multi #(.CH(CH), .W(W), .DEF_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .div_i(div_i), .div_load_i(div_load_i),
    .sync_i(sync_i), .clk_o(clk_o), .ce_o(ce_o), .pend_o(pend_o)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(string tag, int ph[CH], int dv[CH], logic [CH-1:0] pend, logic [CH-1:0] msk);
    exp_t r;
    r.tag  = tag;
    r.pend = pend;
    r.msk  = msk;
    for (int c = 0; c < CH; c++) begin
      r.ce[c]  = dv[c] == 0 ? 1'b0 : (ph[c] % dv[c]) == 0;
      r.clk[c] = dv[c] == 0 ? 1'b0 : (ph[c] % dv[c]) < (dv[c] + 1) / 2;
    end
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    div_i = '0;
    div_load_i = '0;
    sync_i = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    q.push_back(mk("rst_async", '{0, 0, 0, 0}, '{0, 0, 0, 0}, 4'h0, 4'hF));
    #1 e = q.pop_front(); checks++;
    if ((ce_o & e.msk) !== (e.ce & e.msk) || (clk_o & e.msk) !== (e.clk & e.msk) || (pend_o & e.msk) !== (e.pend & e.msk)) begin
      failures++;
      $display("FAIL %s t=%0t got ce=%b clk=%b pend=%b want ce=%b clk=%b pend=%b", e.tag, $time, ce_o, clk_o, pend_o, e.ce, e.clk, e.pend);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      q.push_back(mk("rst_default", '{n-1, n-1, n-1, n-1}, '{2, 2, 2, 2}, 4'h0, 4'hF));
      tick(); e = q.pop_front(); checks++;
      if ((ce_o & e.msk) !== (e.ce & e.msk) || (clk_o & e.msk) !== (e.clk & e.msk) || (pend_o & e.msk) !== (e.pend & e.msk)) begin
        failures++;
        $display("FAIL %s cyc=%0d got ce=%b clk=%b pend=%b want ce=%b clk=%b pend=%b", e.tag, n, ce_o, clk_o, pend_o, e.ce, e.clk, e.pend);
      end
    end
  endtask

  task automatic test_odd_ratio;
    do_reset();
    q.push_back(mk("odd_c1", '{0, 0, 0, 0}, '{2, 2, 2, 2}, 4'h0, 4'h1));
    tick(); e = q.pop_front(); checks++;
    if ((ce_o & e.msk) !== (e.ce & e.msk) || (clk_o & e.msk) !== (e.clk & e.msk) || (pend_o & e.msk) !== (e.pend & e.msk)) begin
      failures++;
      $display("FAIL %s got ce=%b clk=%b pend=%b want ce=%b clk=%b pend=%b", e.tag, ce_o, clk_o, pend_o, e.ce, e.clk, e.pend);
    end
    div_i[7:0] = 8'd5;
    div_load_i = 4'h1;
    q.push_back(mk("odd_pend", '{1, 0, 0, 0}, '{2, 2, 2, 2}, 4'h1, 4'h1));
    tick(); e = q.pop_front(); checks++;
    if ((ce_o & e.msk) !== (e.ce & e.msk) || (clk_o & e.msk) !== (e.clk & e.msk) || (pend_o & e.msk) !== (e.pend & e.msk)) begin
      failures++;
      $display("FAIL %s got ce=%b clk=%b pend=%b want ce=%b clk=%b pend=%b", e.tag, ce_o, clk_o, pend_o, e.ce, e.clk, e.pend);
    end
    div_load_i = '0;
    for (int k = 0; k < 12; k++) begin
      q.push_back(mk("odd_run", '{k, 0, 0, 0}, '{5, 0, 0, 0}, 4'h0, 4'h1));
      tick(); e = q.pop_front(); checks++;
      if ((ce_o & e.msk) !== (e.ce & e.msk) || (clk_o & e.msk) !== (e.clk & e.msk) || (pend_o & e.msk) !== (e.pend & e.msk)) begin
        failures++;
        $display("FAIL %s k=%0d got ce=%b clk=%b pend=%b want ce=%b clk=%b pend=%b", e.tag, k, ce_o, clk_o, pend_o, e.ce, e.clk, e.pend);
      end
    end
  endtask

  task automatic test_reload;
    do_reset();
    tick();
    div_i[7:0] = 8'd5;
    div_load_i = 4'h1;
    tick();
    div_load_i = '0;
    repeat (2) tick();
    for (int k = 2; k <= 4; k++) begin
      if (k == 2) begin div_i[7:0] = 8'd3; div_load_i = 4'h1; end
      if (k == 3) begin div_i[7:0] = 8'd7; div_load_i = 4'h1; end
      if (k == 4) div_load_i = '0;
      q.push_back(mk("reload_old", '{k, 0, 0, 0}, '{5, 0, 0, 0}, 4'h1, 4'h1));
      tick(); e = q.pop_front(); checks++;
      if ((ce_o & e.msk) !== (e.ce & e.msk) || (clk_o & e.msk) !== (e.clk & e.msk) || (pend_o & e.msk) !== (e.pend & e.msk)) begin
        failures++;
        $display("FAIL %s ph=%0d got ce=%b clk=%b pend=%b want ce=%b clk=%b pend=%b", e.tag, k, ce_o, clk_o, pend_o, e.ce, e.clk, e.pend);
      end
    end
    for (int k = 0; k < 21; k++) begin
      q.push_back(mk("reload_new", '{k, 0, 0, 0}, '{7, 0, 0, 0}, 4'h0, 4'h1));
      tick(); e = q.pop_front(); checks++;
      if ((ce_o & e.msk) !== (e.ce & e.msk) || (clk_o & e.msk) !== (e.clk & e.msk) || (pend_o & e.msk) !== (e.pend & e.msk)) begin
        failures++;
        $display("FAIL %s k=%0d got ce=%b clk=%b pend=%b want ce=%b clk=%b pend=%b", e.tag, k, ce_o, clk_o, pend_o, e.ce, e.clk, e.pend);
      end
    end
  endtask

  task automatic test_disable_enable;
    do_reset();
    tick();
    div_i[7:0] = 8'd0;
    div_load_i = 4'h1;
    for (int k = 0; k < 14; k++) begin
      if (k == 1) div_load_i = '0;
      if (k == 5) begin div_i[7:0] = 8'd4; div_load_i = 4'h1; end
      if (k == 6) div_load_i = '0;
      if (k == 0)
        q.push_back(mk("dis_pend", '{1, 0, 0, 0}, '{2, 0, 0, 0}, 4'h1, 4'h1));
      else if (k < 5)
        q.push_back(mk("dis_low", '{0, 0, 0, 0}, '{0, 0, 0, 0}, 4'h0, 4'h1));
      else
        q.push_back(mk("en_run", '{k-5, 0, 0, 0}, '{4, 0, 0, 0}, 4'h0, 4'h1));
      tick(); e = q.pop_front(); checks++;
      if ((ce_o & e.msk) !== (e.ce & e.msk) || (clk_o & e.msk) !== (e.clk & e.msk) || (pend_o & e.msk) !== (e.pend & e.msk)) begin
        failures++;
        $display("FAIL %s k=%0d got ce=%b clk=%b pend=%b want ce=%b clk=%b pend=%b", e.tag, k, ce_o, clk_o, pend_o, e.ce, e.clk, e.pend);
      end
    end
  endtask

  task automatic test_sync;
    do_reset();
    tick();
    div_i = {8'd0, 8'd6, 8'd4, 8'd3};
    div_load_i = 4'hF;
    q.push_back(mk("sync_pend", '{1, 1, 1, 1}, '{2, 2, 2, 2}, 4'hF, 4'hF));
    tick(); e = q.pop_front(); checks++;
    if ((ce_o & e.msk) !== (e.ce & e.msk) || (clk_o & e.msk) !== (e.clk & e.msk) || (pend_o & e.msk) !== (e.pend & e.msk)) begin
      failures++;
      $display("FAIL %s got ce=%b clk=%b pend=%b want ce=%b clk=%b pend=%b", e.tag, ce_o, clk_o, pend_o, e.ce, e.clk, e.pend);
    end
    div_load_i = '0;
    for (int k = 0; k < 2; k++) begin
      q.push_back(mk("sync_pre", '{k, k, k, k}, '{3, 4, 6, 0}, 4'h0, 4'hF));
      tick(); e = q.pop_front(); checks++;
      if ((ce_o & e.msk) !== (e.ce & e.msk) || (clk_o & e.msk) !== (e.clk & e.msk) || (pend_o & e.msk) !== (e.pend & e.msk)) begin
        failures++;
        $display("FAIL %s k=%0d got ce=%b clk=%b pend=%b want ce=%b clk=%b pend=%b", e.tag, k, ce_o, clk_o, pend_o, e.ce, e.clk, e.pend);
      end
    end
    sync_i = 1'b1;
    div_i[15:8] = 8'd8;
    div_load_i = 4'h2;
    for (int k = 0; k < 18; k++) begin
      if (k == 1) begin sync_i = 1'b0; div_load_i = '0; end
      q.push_back(mk("sync_run", '{k, k, k, k}, '{3, 8, 6, 0}, 4'h0, 4'hF));
      tick(); e = q.pop_front(); checks++;
      if ((ce_o & e.msk) !== (e.ce & e.msk) || (clk_o & e.msk) !== (e.clk & e.msk) || (pend_o & e.msk) !== (e.pend & e.msk)) begin
        failures++;
        $display("FAIL %s k=%0d got ce=%b clk=%b pend=%b want ce=%b clk=%b pend=%b", e.tag, k, ce_o, clk_o, pend_o, e.ce, e.clk, e.pend);
      end
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    tick();
    div_i[7:0] = 8'd9;
    div_load_i = 4'h1;
    tick();
    div_load_i = '0;
    repeat (3) tick();
    div_i[7:0] = 8'd5;
    div_load_i = 4'h1;
    q.push_back(mk("mid_pend", '{3, 0, 0, 0}, '{9, 0, 0, 0}, 4'h1, 4'h1));
    tick(); e = q.pop_front(); checks++;
    if ((ce_o & e.msk) !== (e.ce & e.msk) || (clk_o & e.msk) !== (e.clk & e.msk) || (pend_o & e.msk) !== (e.pend & e.msk)) begin
      failures++;
      $display("FAIL %s got ce=%b clk=%b pend=%b want ce=%b clk=%b pend=%b", e.tag, ce_o, clk_o, pend_o, e.ce, e.clk, e.pend);
    end
    div_load_i = '0;
    #2 rst_n = 1'b0;
    q.push_back(mk("mid_rst", '{0, 0, 0, 0}, '{0, 0, 0, 0}, 4'h0, 4'hF));
    #1 e = q.pop_front(); checks++;
    if ((ce_o & e.msk) !== (e.ce & e.msk) || (clk_o & e.msk) !== (e.clk & e.msk) || (pend_o & e.msk) !== (e.pend & e.msk)) begin
      failures++;
      $display("FAIL %s got ce=%b clk=%b pend=%b want ce=%b clk=%b pend=%b", e.tag, ce_o, clk_o, pend_o, e.ce, e.clk, e.pend);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      q.push_back(mk("mid_after", '{k, k, k, k}, '{2, 2, 2, 2}, 4'h0, 4'hF));
      tick(); e = q.pop_front(); checks++;
      if ((ce_o & e.msk) !== (e.ce & e.msk) || (clk_o & e.msk) !== (e.clk & e.msk) || (pend_o & e.msk) !== (e.pend & e.msk)) begin
        failures++;
        $display("FAIL %s k=%0d got ce=%b clk=%b pend=%b want ce=%b clk=%b pend=%b", e.tag, k, ce_o, clk_o, pend_o, e.ce, e.clk, e.pend);
      end
    end
  endtask

  initial begin
    test_reset();
    test_odd_ratio();
    test_reload();
    test_disable_enable();
    test_sync();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
